rom_fetch_ctrl: RTL and testbench
=================================

# rom_fetch_ctrl

Instruction-fetch sequencer for the 32-entry × 32-bit instruction ROM (`reg_rom`, combinational read).
- Owns the ROM address, stepping a program counter through it.
- Captures each word into a 2-entry prefetch buffer and presents words to decode through a valid/ready handshake.
- Supports redirect (branch/jump target) with buffer flush, and optional halt on EBREAK.

## Interface
Parameters:
- ADDR_W, 5, ROM address width (ROM depth 2^ADDR_W)
- DATA_W, 32, instruction width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin fetching from address 0 (honoured in IDLE/HALT only)
- rom_addr  out  ADDR_W  ROM address (registered PC)
- rom_q  in  DATA_W  ROM read data, valid same cycle as rom_addr
- redirect  in  1  flush buffer, continue fetch at redirect_addr
- redirect_addr  in  ADDR_W  redirect target
- instr  out  DATA_W  head-of-buffer instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  consumer accepts head when high with instr_valid
- busy  out  1  state is FETCH
- halted  out  1  state is HALT

## Operation
- States:
  - IDLE: reset state.
  - FETCH: active fetching.
  - HALT: stopped after EBREAK, only with FETCH_HALT_EN.
- IDLE/HALT → FETCH:
  - On start: pc=0.
  - On redirect: pc=redirect_addr; redirect has priority over start.
  - Buffer is cleared on entry.
- FETCH, each edge:
  - Push {rom_q, pc} when buffer has space, counting a same-edge pop as freeing space.
  - On push, pc=pc+1 modulo 2^ADDR_W (31→0 wrap).
- Pop: at an edge where instr_valid && instr_ready, the head is removed. Order is FIFO, depth 2. instr_valid = occupancy≠0.
- Redirect in FETCH:
  - Buffer flushed (occupancy 0) and pc=redirect_addr at that edge; no push that edge.
  - A same-edge handshake counts as accepted by the consumer. The buffer is flushed regardless.
- start while in FETCH: ignored.
- Outputs when the buffer is empty: instr/instr_pc hold their last value; consumers gate on instr_valid.
- Reset values: rom_addr=0, pc=0, occupancy=0, instr=0, instr_pc=0, instr_valid=0, busy=0, halted=0, state=IDLE.
- Reset asserted mid-fetch: everything returns to reset values immediately (asynchronous), buffer contents discarded.

## Timing
- Fetch latency:
  - start sampled at edge N → busy=1 and rom_addr=0 after N.
  - Word 0 pushed at N+1 → instr_valid=1 after N+1.
- Throughput: with instr_ready held high, 1 instruction/cycle; occupancy stays 1.
- With instr_ready low: buffer fills in 2 pushes; rom_addr then freezes at the next unfetched address.
- Redirect sampled at edge R:
  - instr_valid=0 after R.
  - First target word is valid after R+1.
- Full and pop on the same edge: push and pop both occur; occupancy stays 2.

## Configuration
- FETCH_HALT_EN defined:
  - When a pushed word equals 32'h00100073 (EBREAK), fetching stops: no further pushes, pc holds at EBREAK address+1.
  - Already-buffered words, including the EBREAK, drain normally.
  - The edge that pops the EBREAK entry moves FETCH→HALT: halted=1, busy=0.
  - Redirect before that pop flushes the buffer and cancels the stop.
- FETCH_HALT_EN undefined:
  - EBREAK is an ordinary word and fetch runs indefinitely with wrap-around.
  - HALT state is unreachable and halted is tied 0.

## Test plan
- Reset mid-fetch: rst_n low while occupancy=2 → all outputs 0, state IDLE, instr_valid=0 in the same cycle.
- Streaming wrap: ROM[i]=32'hA000_0000+i, start, instr_ready=1 → instr_valid rises 2 edges after start; instr_pc sequence 0,1,…,31,0,1 at one per cycle with instr=ROM[instr_pc].
- Backpressure: instr_ready=0 after start → occupancy 2 holding pc 0,1, rom_addr=2 frozen. Then release ready → words 0,1,2,… delivered without gap or duplication.
- Redirect vs. pop: occupancy 2 at pc 4,5; pulse redirect with redirect_addr=20 and instr_ready=1 on the same edge → instr_valid=0 next cycle; next delivered instr_pc=20, then 21.
- Halt (FETCH_HALT_EN):
  - ROM[3]=32'h00100073 → delivered pcs 0..3 only; halted=1 after the pop of pc 3; rom_addr=4 held.
  - Then start → halted=0, fetch restarts at pc 0.
- No halt (FETCH_HALT_EN undefined): same ROM → pc 3 delivered then 4, 5, … continuous; halted stays 0.

Source files
------------

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: steps a PC through a combinational ROM into a 2-deep prefetch buffer.
// Optional halt-on-EBREAK is enabled by defining FETCH_HALT_EN.
module rom_fetch_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [1:0]        cnt, cnt_nx;
    logic [DATA_W-1:0] h_instr, h_instr_nx, t_instr, t_instr_nx;
    logic [ADDR_W-1:0] h_pc, h_pc_nx, t_pc, t_pc_nx;
    logic              pop, push;
`ifdef FETCH_HALT_EN
    localparam logic [DATA_W-1:0] EBREAK = DATA_W'(32'h0010_0073);
    logic              stop, stop_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            cnt     <= '0;
            h_instr <= '0;
            h_pc    <= '0;
            t_instr <= '0;
            t_pc    <= '0;
`ifdef FETCH_HALT_EN
            stop    <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            cnt     <= cnt_nx;
            h_instr <= h_instr_nx;
            h_pc    <= h_pc_nx;
            t_instr <= t_instr_nx;
            t_pc    <= t_pc_nx;
`ifdef FETCH_HALT_EN
            stop    <= stop_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        cnt_nx     = cnt;
        h_instr_nx = h_instr;
        h_pc_nx    = h_pc;
        t_instr_nx = t_instr;
        t_pc_nx    = t_pc;
        pop        = (cnt != 2'd0) && instr_ready;
        push       = 1'b0;
`ifdef FETCH_HALT_EN
        stop_nx    = stop;
`endif
        case (state)
            S_IDLE, S_HALT: begin
                if (redirect || start) begin
                    state_nx = S_FETCH;
                    pc_nx    = redirect ? redirect_addr : '0;
                    cnt_nx   = '0;
`ifdef FETCH_HALT_EN
                    stop_nx  = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    pc_nx   = redirect_addr;
                    cnt_nx  = '0;
`ifdef FETCH_HALT_EN
                    stop_nx = 1'b0;
`endif
                end else begin
`ifdef FETCH_HALT_EN
                    push = ((cnt != 2'd2) || pop) && !stop;
                    // The EBREAK is always the last entry, so its pop empties the buffer.
                    if (pop && stop && (cnt == 2'd1))
                        state_nx = S_HALT;
                    if (push && (rom_q == EBREAK))
                        stop_nx = 1'b1;
`else
                    push = (cnt != 2'd2) || pop;
`endif
                    cnt_nx = cnt - {1'b0, pop} + {1'b0, push};
                    if (pop && (cnt == 2'd2)) begin
                        h_instr_nx = t_instr;
                        h_pc_nx    = t_pc;
                    end
                    if (push) begin
                        pc_nx = pc + 1'b1;
                        if ((cnt == 2'd0) || ((cnt == 2'd1) && pop)) begin
                            h_instr_nx = rom_q;
                            h_pc_nx    = pc;
                        end else begin
                            t_instr_nx = rom_q;
                            t_pc_nx    = pc;
                        end
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign rom_addr    = pc;
    assign instr       = h_instr;
    assign instr_pc    = h_pc;
    assign instr_valid = (cnt != 2'd0);
    assign busy        = (state == S_FETCH);
`ifdef FETCH_HALT_EN
    assign halted      = (state == S_HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Testbench for rom_fetch_ctrl: directed scenarios plus randomized run against a queue-based model.
module tb_rom_fetch_ctrl;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  rom_addr;
    logic [31:0] rom_q;
    logic        redirect = 1'b0;
    logic [4:0]  redirect_addr = '0;
    logic [31:0] instr;
    logic [4:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        busy;
    logic        halted;

    logic [31:0] rom [32];
    assign rom_q = rom[rom_addr];

    rom_fetch_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
        .redirect(redirect), .redirect_addr(redirect_addr), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: 0 idle, 1 fetch, 2 halt; buffer as queues of (pc, word).
    int          m_state;
    int          m_pc;
    bit          m_stop;
    int          qpc[$];
    logic [31:0] qw[$];
    int          last_pc;
    logic [31:0] last_w;

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_stop = 0;
        qpc.delete(); qw.delete();
        last_pc = 0; last_w = '0;
    endtask

    task automatic step();
        bit          pop;
        logic [31:0] pw;
        if (rst_n) begin
            pop = (qpc.size() != 0) && instr_ready;
            if (m_state != 1) begin
                if (redirect || start) begin
                    m_state = 1;
                    m_pc = redirect ? int'(redirect_addr) : 0;
                    qpc.delete(); qw.delete(); m_stop = 0;
                end
            end else if (redirect) begin
                qpc.delete(); qw.delete();
                m_pc = int'(redirect_addr); m_stop = 0;
            end else begin
                if (pop) begin
                    qpc.delete(0);
                    pw = qw.pop_front();
                    if (HALT_EN && m_stop && pw == EBREAK) m_state = 2;
                end
                if (m_state == 1 && !m_stop && qpc.size() < 2) begin
                    qpc.push_back(m_pc);
                    qw.push_back(rom[m_pc]);
                    if (HALT_EN && rom[m_pc] == EBREAK) m_stop = 1;
                    m_pc = (m_pc + 1) % 32;
                end
            end
            if (qpc.size() != 0) begin
                last_pc = qpc[0];
                last_w = qw[0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + i;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load_ramp();
        do_reset();
        n_checks++; if (rom_addr !== 5'd0) $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
        n_checks++; if ({busy, halted} !== 2'b00) $display("FAIL reset_busy_halted: got %b want 00", {busy, halted}); else n_pass++;
        n_checks++; if ({instr, instr_pc} !== 37'd0) $display("FAIL reset_instr: got %h/%0d want 0/0", instr, instr_pc); else n_pass++;
    endtask

    task automatic test_stream_wrap();
        load_ramp();
        do_reset();
        instr_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if ({busy, rom_addr, instr_valid} !== {1'b1, 5'd0, 1'b0})
            $display("FAIL stream_after_start: got busy=%b addr=%0d valid=%b want 1/0/0", busy, rom_addr, instr_valid); else n_pass++;
        for (int k = 0; k < 34; k++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 5'(k % 32) || instr !== 32'hA000_0000 + (k % 32))
                $display("FAIL stream_word%0d: got v=%b pc=%0d instr=%h want 1/%0d/%h", k, instr_valid, instr_pc, instr,
                         k % 32, 32'hA000_0000 + (k % 32));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        load_ramp();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_checks++; if ({instr_valid, instr_pc, rom_addr} !== {1'b1, 5'd0, 5'd2})
            $display("FAIL bp_full: got v=%b pc=%0d addr=%0d want 1/0/2", instr_valid, instr_pc, rom_addr); else n_pass++;
        instr_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            step();
            n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'(k))
                $display("FAIL bp_release%0d: got v=%b pc=%0d want 1/%0d", k, instr_valid, instr_pc, k); else n_pass++;
        end
    endtask

    task automatic test_redirect_pop();
        load_ramp();
        do_reset();
        instr_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        instr_ready = 1'b0;
        step();
        n_checks++; if ({instr_pc, rom_addr} !== {5'd4, 5'd6})
            $display("FAIL redir_setup: got pc=%0d addr=%0d want 4/6", instr_pc, rom_addr); else n_pass++;
        instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 5'd20;
        step();
        redirect = 1'b0;
        n_checks++; if ({instr_valid, rom_addr} !== {1'b0, 5'd20})
            $display("FAIL redir_flush: got v=%b addr=%0d want 0/20", instr_valid, rom_addr); else n_pass++;
        step();
        n_checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 5'd20, 32'hA000_0014})
            $display("FAIL redir_first: got v=%b pc=%0d instr=%h want 1/20/a0000014", instr_valid, instr_pc, instr); else n_pass++;
        step();
        n_checks++; if ({instr_valid, instr_pc} !== {1'b1, 5'd21})
            $display("FAIL redir_second: got v=%b pc=%0d want 1/21", instr_valid, instr_pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        load_ramp();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if ({instr_valid, busy, halted, rom_addr, instr_pc, instr} !== 45'd0)
            $display("FAIL reset_mid: got v=%b busy=%b halted=%b addr=%0d pc=%0d instr=%h want all 0",
                     instr_valid, busy, halted, rom_addr, instr_pc, instr); else n_pass++;
        step();
        rst_n = 1'b1;
        n_checks++; if ({instr_valid, busy} !== 2'b00)
            $display("FAIL reset_mid_hold: got v=%b busy=%b want 0/0", instr_valid, busy); else n_pass++;
    endtask

    task automatic test_halt();
        load_ramp();
        rom[3] = EBREAK;
        do_reset();
        instr_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'(k))
                $display("FAIL halt_deliver%0d: got v=%b pc=%0d want 1/%0d", k, instr_valid, instr_pc, k); else n_pass++;
        end
        step();
        if (HALT_EN) begin
            n_checks++; if ({halted, busy, instr_valid, rom_addr} !== {1'b1, 1'b0, 1'b0, 5'd4})
                $display("FAIL halt_enter: got h=%b b=%b v=%b addr=%0d want 1/0/0/4", halted, busy, instr_valid, rom_addr); else n_pass++;
            step(); step(); step();
            n_checks++; if ({halted, instr_valid, rom_addr} !== {1'b1, 1'b0, 5'd4})
                $display("FAIL halt_hold: got h=%b v=%b addr=%0d want 1/0/4", halted, instr_valid, rom_addr); else n_pass++;
            start = 1'b1;
            step();
            start = 1'b0;
            n_checks++; if ({halted, busy, rom_addr} !== {1'b0, 1'b1, 5'd0})
                $display("FAIL halt_restart: got h=%b b=%b addr=%0d want 0/1/0", halted, busy, rom_addr); else n_pass++;
            step();
            n_checks++; if ({instr_valid, instr_pc} !== {1'b1, 5'd0})
                $display("FAIL halt_restart_word: got v=%b pc=%0d want 1/0", instr_valid, instr_pc); else n_pass++;
        end else begin
            for (int k = 4; k < 8; k++) begin
                n_checks++; if ({instr_valid, instr_pc, halted} !== {1'b1, 5'(k), 1'b0})
                    $display("FAIL nohalt_word%0d: got v=%b pc=%0d h=%b want 1/%0d/0", k, instr_valid, instr_pc, halted, k); else n_pass++;
                step();
            end
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 32; i++) rom[i] = ($urandom_range(0, 9) == 0) ? EBREAK : $urandom;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_addr = 5'($urandom);
            start = ($urandom_range(0, 14) == 0);
            step();
            n_checks++;
            if (instr_valid !== (qpc.size() != 0) || instr_pc !== 5'(last_pc) || instr !== last_w ||
                rom_addr !== 5'(m_pc) || busy !== (m_state == 1) || halted !== (m_state == 2)) begin
                if (errs < 10)
                    $display("FAIL random_cycle%0d: got v=%b pc=%0d instr=%h addr=%0d b=%b h=%b want %b/%0d/%h/%0d/%b/%b",
                             c, instr_valid, instr_pc, instr, rom_addr, busy, halted,
                             qpc.size() != 0, last_pc, last_w, m_pc, m_state == 1, m_state == 2);
                errs++;
            end else n_pass++;
        end
        start = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream_wrap();
        test_backpressure();
        test_redirect_pop();
        test_reset_mid();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
